// File: rtl/enemy_fire_if.sv
// enemy_fire_if
//   Bundle between the enemy-position logic, the enemy fire scheduler and
//   the pool of per-slot missile controllers.
//   Signals:
//     enable       gameplay running
//     enemy_alive  bit i = enemy i alive
//     enemy_xpos   packed x positions, enemy i at [12*i +: 12]
//     enemy_ypos   packed y positions, same packing
//     slot_busy    on_out of each missile slot
//     fire_req     one-hot, one-cycle fire pulse to the chosen slot
//     fire_xpos    muzzle x of the last issued shot
//     fire_ypos    muzzle y of the last issued shot
//     fire_src     index of the enemy that fired
//   Modports:
//     master  the scheduler (drives the fire_* outputs)
//     slave   the surrounding game logic / missile pool
interface enemy_fire_if #(
  parameter int N_EN   = 4,
  parameter int N_SLOT = 2
);
  logic                 enable;
  logic [N_EN-1:0]      enemy_alive;
  logic [12*N_EN-1:0]   enemy_xpos;
  logic [12*N_EN-1:0]   enemy_ypos;
  logic [N_SLOT-1:0]    slot_busy;
  logic [N_SLOT-1:0]    fire_req;
  logic [11:0]          fire_xpos;
  logic [11:0]          fire_ypos;
  logic [1:0]           fire_src;

  modport master (
    input  enable, enemy_alive, enemy_xpos, enemy_ypos, slot_busy,
    output fire_req, fire_xpos, fire_ypos, fire_src
  );

  modport slave (
    output enable, enemy_alive, enemy_xpos, enemy_ypos, slot_busy,
    input  fire_req, fire_xpos, fire_ypos, fire_src
  );
endinterface

// File: rtl/enemy_fire_scheduler.sv
// enemy_fire_scheduler
//   Decides when enemies shoot and which enemy fires from which missile slot.
//   Every FIRE_PERIOD enabled cycles one alive enemy and one free slot are
//   picked, and that slot gets a one-cycle fire request carrying the enemy's
//   muzzle position (enemy position plus X_OFFSET / Y_OFFSET, modulo 4096).
//   Ports:
//     pclk  pixel clock
//     rst   synchronous reset, active high
//     bus   enemy_fire_if.master (enable, enemy_alive, enemy_xpos,
//           enemy_ypos, slot_busy in; fire_req, fire_xpos, fire_ypos,
//           fire_src out)
//   Configuration:
//     ENEMY_FIRE_LFSR_EN  when defined, the enemy scan starts at the low two
//                         bits of a free-running 16-bit LFSR instead of the
//                         round-robin pointer.
module enemy_fire_scheduler #(
  parameter int N_EN        = 4,
  parameter int N_SLOT      = 2,
  parameter int FIRE_PERIOD = 650000,
  parameter int X_OFFSET    = 24,
  parameter int Y_OFFSET    = 64,
  parameter int HOLD_MAX    = 4
) (
  input logic          pclk,
  input logic          rst,
  enemy_fire_if.master bus
);

  localparam int CNT_W  = $clog2(FIRE_PERIOD);
  localparam int SLOT_W = (N_SLOT > 1) ? $clog2(N_SLOT) : 1;
  localparam int HOLD_W = $clog2(HOLD_MAX + 1);

  localparam logic [1:0] WAIT   = 2'd0;
  localparam logic [1:0] SELECT = 2'd1;
  localparam logic [1:0] ISSUE  = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [1:0]        sel_en;
  logic [SLOT_W-1:0] sel_slot;
  logic [11:0]       sel_x;
  logic [11:0]       sel_y;

  logic [1:0]        start_idx;
  logic [1:0]        scan_idx;
  logic              en_found;
  logic [1:0]        en_pick;
  logic              slot_found;
  logic [SLOT_W-1:0] slot_pick;
  logic [11:0]       pos_x;
  logic [11:0]       pos_y;

`ifdef ENEMY_FIRE_LFSR_EN
  // Fibonacci LFSR, taps 16,14,13,11, runs every cycle regardless of state.
  logic [15:0] lfsr;

  always_ff @(posedge pclk) begin
    if (rst)
      lfsr <= 16'hACE1;
    else
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign start_idx = lfsr[1:0];
`else
  logic [1:0] rr_ptr;

  // The pointer moves past the chosen enemy even when the shot was cancelled
  // because that enemy died, so a dead pick never stalls the rotation.
  always_ff @(posedge pclk) begin
    if (rst)
      rr_ptr <= 2'd0;
    else if (state == ISSUE)
      rr_ptr <= sel_en + 2'd1;
  end

  assign start_idx = rr_ptr;
`endif

  // Scan downward so the alive enemy closest to start_idx (wrapping) wins.
  always_comb begin
    en_found = 1'b0;
    en_pick  = start_idx;
    scan_idx = start_idx;
    for (int i = N_EN - 1; i >= 0; i--) begin
      scan_idx = start_idx + 2'(i);
      if (bus.enemy_alive[scan_idx]) begin
        en_found = 1'b1;
        en_pick  = scan_idx;
      end
    end
  end

  always_comb begin
    slot_found = 1'b0;
    slot_pick  = '0;
    for (int s = N_SLOT - 1; s >= 0; s--) begin
      if (!bus.slot_busy[s]) begin
        slot_found = 1'b1;
        slot_pick  = SLOT_W'(s);
      end
    end
  end

  always_comb begin
    pos_x = '0;
    pos_y = '0;
    for (int i = 0; i < N_EN; i++) begin
      if (en_pick == 2'(i)) begin
        pos_x = bus.enemy_xpos[12*i +: 12];
        pos_y = bus.enemy_ypos[12*i +: 12];
      end
    end
  end

  // The period counter only advances in WAIT and is already zero on leaving
  // it. HOLD keeps a just-fired slot from being picked again before its
  // busy flag has had time to rise.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state         <= WAIT;
      cnt           <= '0;
      hold_cnt      <= '0;
      sel_en        <= 2'd0;
      sel_slot      <= '0;
      sel_x         <= 12'd0;
      sel_y         <= 12'd0;
      bus.fire_req  <= '0;
      bus.fire_xpos <= 12'd0;
      bus.fire_ypos <= 12'd0;
      bus.fire_src  <= 2'd0;
    end else begin
      bus.fire_req <= '0;
      case (state)
        WAIT: begin
          if (bus.enable) begin
            if (cnt == CNT_W'(FIRE_PERIOD - 1)) begin
              cnt   <= '0;
              state <= SELECT;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        SELECT: begin
          if (en_found && slot_found) begin
            sel_en   <= en_pick;
            sel_slot <= slot_pick;
            sel_x    <= pos_x + 12'(X_OFFSET);
            sel_y    <= pos_y + 12'(Y_OFFSET);
            hold_cnt <= '0;
            state    <= ISSUE;
          end else begin
            state <= WAIT;
          end
        end
        ISSUE: begin
          if (bus.enemy_alive[sel_en]) begin
            bus.fire_req  <= N_SLOT'(1) << sel_slot;
            bus.fire_xpos <= sel_x;
            bus.fire_ypos <= sel_y;
            bus.fire_src  <= sel_en;
          end
          state <= HOLD;
        end
        HOLD: begin
          if (bus.slot_busy[sel_slot] || hold_cnt == HOLD_W'(HOLD_MAX - 1))
            state <= WAIT;
          else
            hold_cnt <= hold_cnt + 1'b1;
        end
        default: state <= WAIT;
      endcase
    end
  end

endmodule
